// File: rtl/alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arbiter - two-requester arbiter/sequencer feeding one combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins). Rev 1.0
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clock,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [NB_DATA-1:0] i_req0_data_a,
  input  logic [NB_DATA-1:0] i_req0_data_b,
  input  logic [NB_OP-1:0]   i_req0_op,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [NB_DATA-1:0] i_req1_data_a,
  input  logic [NB_DATA-1:0] i_req1_data_b,
  input  logic [NB_OP-1:0]   i_req1_op,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_zero,
  input  logic               i_alu_carry,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_id,
  output logic [NB_DATA-1:0] o_rsp_result,
  output logic               o_rsp_zero,
  output logic               o_rsp_carry,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   grant_id;
  logic   sel1;
  logic   accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign sel1 = i_req1_valid && !i_req0_valid;
`else
  logic last_grant;
  // Requester 1 wins when alone, or in contention when requester 0 went last.
  assign sel1 = i_req1_valid && (!i_req0_valid || !last_grant);
`endif

  // Reset gating keeps both readies low while i_rst_n is held.
  assign o_req0_ready = i_rst_n && (state == IDLE) && i_req0_valid && !sel1;
  assign o_req1_ready = i_rst_n && (state == IDLE) && sel1;
  assign accept       = o_req0_ready || o_req1_ready;

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      grant_id     <= 1'b0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_zero   <= 1'b0;
      o_rsp_carry  <= 1'b0;
      o_busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_alu_data_a <= sel1 ? i_req1_data_a : i_req0_data_a;
            o_alu_data_b <= sel1 ? i_req1_data_b : i_req0_data_b;
            o_alu_op     <= sel1 ? i_req1_op     : i_req0_op;
            grant_id     <= sel1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant   <= sel1;
`endif
            o_busy       <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          o_rsp_result <= i_alu_result;
          o_rsp_zero   <= i_alu_zero;
          o_rsp_carry  <= i_alu_carry;
          o_rsp_id     <= grant_id;
          o_rsp_valid  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          o_rsp_valid <= 1'b0;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
